// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the four-master rotating bus arbiter:
// owner encoding, master indices and active-low grant levels.
package bus_arbiter_pkg;

  localparam int BUS_OWNER_W = 2;

  typedef logic [BUS_OWNER_W-1:0] owner_t;

  localparam owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam owner_t BUS_OWNER_MASTER_3 = 2'd3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Hold counter must represent 0..HOLD_LIMIT-1; never narrower than one bit.
  function automatic int holdCntWidth(input int limit);
    holdCntWidth = (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the four bus masters and the arbiter.
// All request and grant strobes are active-low.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic   m0Req_;
  logic   m1Req_;
  logic   m2Req_;
  logic   m3Req_;
  logic   m0Grnt_;
  logic   m1Grnt_;
  logic   m2Grnt_;
  logic   m3Grnt_;
  owner_t owner;

  modport master (
    output m0Req_, m1Req_, m2Req_, m3Req_,
    input  m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_, owner
  );

  modport slave (
    input  m0Req_, m1Req_, m2Req_, m3Req_,
    output m0Grnt_, m1Grnt_, m2Grnt_, m3Grnt_, owner
  );

endinterface

// File: rtl/bus_arbiter.sv
// Four-master rotating-priority bus arbiter with parked grant and an
// optional hold limit that forces handoff under sustained contention.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int HOLD_LIMIT = 16
) (
  input logic         clk,
  input logic         reset,
  bus_arbiter_if.slave bus
);

  localparam int CNT_W = holdCntWidth(HOLD_LIMIT);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'((HOLD_LIMIT > 0) ? HOLD_LIMIT - 1 : 0);

  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic [3:0]       reqVec;
  logic             othersReq;
  logic             forceHandoff;

  // First active request strictly after cur in rotation order; cur if none.
  function automatic owner_t nextRequester(input owner_t cur, input logic [3:0] req);
    owner_t idx;
    nextRequester = cur;
    for (int i = 3; i >= 1; i--) begin
      idx = cur + owner_t'(i);
      if (req[idx]) nextRequester = idx;
    end
  endfunction

  always_comb begin
    reqVec       = ~{bus.m3Req_, bus.m2Req_, bus.m1Req_, bus.m0Req_};
    othersReq    = |(reqVec & ~(4'b0001 << owner_q));
    forceHandoff = (HOLD_LIMIT > 0) && othersReq && (holdCnt_q == HOLD_MAX);
    owner_d      = owner_q;
    holdCnt_d    = holdCnt_q;

    if (!reqVec[owner_q] || forceHandoff) owner_d = nextRequester(owner_q, reqVec);

    // Counter tracks contention against the current owner only.
    if ((owner_d != owner_q) || !othersReq) holdCnt_d = '0;
    else if (holdCnt_q != HOLD_MAX)         holdCnt_d = holdCnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q   <= BUS_OWNER_MASTER_0;
      holdCnt_q <= '0;
    end else begin
      owner_q   <= owner_d;
      holdCnt_q <= holdCnt_d;
    end
  end

  // Grants depend on the owner register alone, so they cannot glitch on requests.
  assign bus.m0Grnt_ = (owner_q == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
  assign bus.m1Grnt_ = (owner_q == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
  assign bus.m2Grnt_ = (owner_q == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
  assign bus.m3Grnt_ = (owner_q == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: four instances with different hold limits
// share one clock and reset and are exercised one at a time.
module tb_bus_arbiter;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;
  logic stayed;

  bus_arbiter_if ifA ();
  bus_arbiter_if ifB ();
  bus_arbiter_if ifC ();
  bus_arbiter_if ifD ();

  bus_arbiter #(.HOLD_LIMIT(16)) dut_a (.clk(clk), .reset(reset), .bus(ifA.slave));
  bus_arbiter #(.HOLD_LIMIT(4))  dut_b (.clk(clk), .reset(reset), .bus(ifB.slave));
  bus_arbiter #(.HOLD_LIMIT(0))  dut_c (.clk(clk), .reset(reset), .bus(ifC.slave));
  bus_arbiter #(.HOLD_LIMIT(1))  dut_d (.clk(clk), .reset(reset), .bus(ifD.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    {ifA.m3Req_, ifA.m2Req_, ifA.m1Req_, ifA.m0Req_} = 4'b1111;
    {ifB.m3Req_, ifB.m2Req_, ifB.m1Req_, ifB.m0Req_} = 4'b1111;
    {ifC.m3Req_, ifC.m2Req_, ifC.m1Req_, ifC.m0Req_} = 4'b1111;
    {ifD.m3Req_, ifD.m2Req_, ifD.m1Req_, ifD.m0Req_} = 4'b1111;
    reset = 1'b1;

    #2;
    checkOutput("resetOwner", 32'(ifA.owner), 0);
    checkOutput("resetGrants", 32'({ifA.m3Grnt_, ifA.m2Grnt_, ifA.m1Grnt_, ifA.m0Grnt_}), 32'hE);
    checkOutput("resetCnt", 32'(dut_a.holdCnt_q), 0);
    tick(2);
    reset = 1'b0;

    // Idle bus stays parked on master 0.
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idleOwner", 32'(ifA.owner), 0);
      checkOutput("idleGrant0", 32'(ifA.m0Grnt_), 0);
    end

    // Lone request from master 2, then release: bus parks on 2.
    ifA.m2Req_ = 1'b0;
    tick();
    checkOutput("m2Owner", 32'(ifA.owner), 2);
    checkOutput("m2Grants", 32'({ifA.m3Grnt_, ifA.m2Grnt_, ifA.m1Grnt_, ifA.m0Grnt_}), 32'hB);
    ifA.m2Req_ = 1'b1;
    tick();
    checkOutput("parkOwner", 32'(ifA.owner), 2);
    tick();
    checkOutput("parkOwner2", 32'(ifA.owner), 2);
    checkOutput("parkGrants", 32'({ifA.m3Grnt_, ifA.m2Grnt_, ifA.m1Grnt_, ifA.m0Grnt_}), 32'hB);

    // Rotation through 0 -> 1 -> 3 -> 0 with wrap.
    ifA.m0Req_ = 1'b0;
    tick();
    checkOutput("rotTo0", 32'(ifA.owner), 0);
    ifA.m1Req_ = 1'b0;
    ifA.m3Req_ = 1'b0;
    tick();
    checkOutput("rotHold0", 32'(ifA.owner), 0);
    checkOutput("rotCnt1", 32'(dut_a.holdCnt_q), 1);
    ifA.m0Req_ = 1'b1;
    tick();
    checkOutput("rotTo1", 32'(ifA.owner), 1);
    checkOutput("rotCntClr", 32'(dut_a.holdCnt_q), 0);
    ifA.m1Req_ = 1'b1;
    tick();
    checkOutput("rotTo3", 32'(ifA.owner), 3);
    ifA.m3Req_ = 1'b1;
    ifA.m0Req_ = 1'b0;
    tick();
    checkOutput("rotWrap0", 32'(ifA.owner), 0);
    checkOutput("rotWrapGrants", 32'({ifA.m3Grnt_, ifA.m2Grnt_, ifA.m1Grnt_, ifA.m0Grnt_}), 32'hE);
    ifA.m0Req_ = 1'b1;
    tick();
    checkOutput("noContCnt", 32'(dut_a.holdCnt_q), 0);

    // Hold limit 4: owner 1 loses the bus on the 4th contention edge.
    ifB.m1Req_ = 1'b0;
    tick();
    checkOutput("b_own1", 32'(ifB.owner), 1);
    ifB.m2Req_ = 1'b0;
    tick(3);
    checkOutput("b_hold3", 32'(ifB.owner), 1);
    checkOutput("b_cnt3", 32'(dut_b.holdCnt_q), 3);
    tick();
    checkOutput("b_force2", 32'(ifB.owner), 2);
    checkOutput("b_cntClr", 32'(dut_b.holdCnt_q), 0);
    ifB.m1Req_ = 1'b1;
    ifB.m2Req_ = 1'b1;

    // Hold limit 0: no forced handoff however long the contention lasts.
    ifC.m3Req_ = 1'b0;
    tick();
    checkOutput("c_own3", 32'(ifC.owner), 3);
    ifC.m0Req_ = 1'b0;
    stayed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ifC.owner !== 2'd3) stayed = 1'b0;
    end
    checkOutput("c_stayed3", 32'(stayed), 1);
    checkOutput("c_cnt0", 32'(dut_c.holdCnt_q), 0);
    ifC.m3Req_ = 1'b1;
    tick();
    checkOutput("c_to0", 32'(ifC.owner), 0);
    ifC.m0Req_ = 1'b1;

    // Hold limit 1: contending masters alternate every cycle.
    ifD.m1Req_ = 1'b0;
    tick();
    checkOutput("d_own1", 32'(ifD.owner), 1);
    ifD.m2Req_ = 1'b0;
    tick();
    checkOutput("d_force2", 32'(ifD.owner), 2);
    tick();
    checkOutput("d_back1", 32'(ifD.owner), 1);
    ifD.m1Req_ = 1'b1;
    ifD.m2Req_ = 1'b1;

    // Asynchronous reset while master 2 owns the bus under contention.
    ifA.m2Req_ = 1'b0;
    ifA.m3Req_ = 1'b0;
    tick();
    checkOutput("a_own2", 32'(ifA.owner), 2);
    tick();
    checkOutput("a_cnt1", 32'(dut_a.holdCnt_q), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncOwner", 32'(ifA.owner), 0);
    checkOutput("asyncGrants", 32'({ifA.m3Grnt_, ifA.m2Grnt_, ifA.m1Grnt_, ifA.m0Grnt_}), 32'hE);
    checkOutput("asyncCnt", 32'(dut_a.holdCnt_q), 0);
    tick();
    reset = 1'b0;
    ifA.m3Req_ = 1'b1;
    #2;
    checkOutput("postRstOwner", 32'(ifA.owner), 0);
    tick();
    checkOutput("firstDecision", 32'(ifA.owner), 2);
    ifA.m2Req_ = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
